// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the shift-add multiplier datapath.
// Issues one-cycle clear/add/sub/shift strobes, one pair per operand bit.
module mult_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Run,
   input  logic          Load_Clear,
   input  logic          M,
   input  logic          Signed_Mode,
   input  logic          Busy,
   output logic          Clr_Ld,
   output logic          Clr_A,
   output logic          Add,
   output logic          Sub,
   output logic          Shift,
   output logic          Done,
   output logic [CW-1:0] Bit_Count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLRA,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          sgn;
   logic          sgn_nxt;
   logic          armed;
   logic          armed_nxt;
   logic          go;
   logic          last_bit;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         sgn   <= 1'b0;
         armed <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sgn   <= sgn_nxt;
         armed <= armed_nxt;
      end
   end

   // Strobes are killed both by a stall and while reset is held,
   // so Clr_Ld cannot follow Load_Clear during reset.
   assign go        = Reset_n & ~Busy;
   assign last_bit  = (cnt == LAST);
   assign Bit_Count = cnt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sgn_nxt   = sgn;
      armed_nxt = armed;
      Clr_Ld    = 1'b0;
      Clr_A     = 1'b0;
      Add       = 1'b0;
      Sub       = 1'b0;
      Shift     = 1'b0;
      Done      = (state == S_DONE);

      unique case (state)
         S_IDLE: begin
            Clr_Ld = go & Load_Clear;
            if (Run && armed) state_nxt = S_CLRA;
         end
         S_CLRA: begin
            Clr_A     = go;
            cnt_nxt   = '0;
            sgn_nxt   = Signed_Mode;
            armed_nxt = 1'b0;
            state_nxt = S_ADD;
         end
         S_ADD: begin
            // Sign bit of a two's-complement multiplier has negative weight
            Sub       = go & M & last_bit & sgn;
            Add       = go & M & ~(last_bit & sgn);
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            Shift     = go;
            cnt_nxt   = cnt + CW'(1);
            state_nxt = last_bit ? S_DONE : S_ADD;
         end
         S_DONE: begin
            Clr_Ld = go & Load_Clear;
            if (Run && armed) state_nxt = S_CLRA;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (!Run) armed_nxt = 1'b1;

      if (Busy) begin
         state_nxt = state;
         cnt_nxt   = cnt;
         sgn_nxt   = sgn;
         armed_nxt = armed;
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: three widths (8, 2, 16) share the control
// inputs and are checked every cycle against a cycle-position model.
module tb_mult_seq_ctrl;

   localparam int NI = 3;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Run;
   logic       Load_Clear;
   logic       Signed_Mode;
   logic       Busy;
   logic [2:0] m;
   logic [2:0] clr_ld;
   logic [2:0] clr_a;
   logic [2:0] add;
   logic [2:0] sub;
   logic [2:0] shift;
   logic [2:0] done;
   logic [3:0] bc0;
   logic [1:0] bc1;
   logic [4:0] bc2;

   int nerr = 0;
   int nchk = 0;
   bit chk_en = 1'b0;

   always #5 Clk = ~Clk;

   mult_seq_ctrl #(.WIDTH(8)) u0 (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run),
      .Load_Clear(Load_Clear), .M(m[0]),
      .Signed_Mode(Signed_Mode), .Busy(Busy),
      .Clr_Ld(clr_ld[0]), .Clr_A(clr_a[0]), .Add(add[0]),
      .Sub(sub[0]), .Shift(shift[0]), .Done(done[0]),
      .Bit_Count(bc0)
   );

   mult_seq_ctrl #(.WIDTH(2)) u1 (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run),
      .Load_Clear(Load_Clear), .M(m[1]),
      .Signed_Mode(Signed_Mode), .Busy(Busy),
      .Clr_Ld(clr_ld[1]), .Clr_A(clr_a[1]), .Add(add[1]),
      .Sub(sub[1]), .Shift(shift[1]), .Done(done[1]),
      .Bit_Count(bc1)
   );

   mult_seq_ctrl #(.WIDTH(16)) u2 (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run),
      .Load_Clear(Load_Clear), .M(m[2]),
      .Signed_Mode(Signed_Mode), .Busy(Busy),
      .Clr_Ld(clr_ld[2]), .Clr_A(clr_a[2]), .Add(add[2]),
      .Sub(sub[2]), .Shift(shift[2]), .Done(done[2]),
      .Bit_Count(bc2)
   );

   function automatic int w_of(input int i);
      case (i)
         0:       return 8;
         1:       return 2;
         default: return 16;
      endcase
   endfunction

   // Model: pos = -1 outside a run, 0 = clear cycle, then odd positions
   // are add decisions and even ones are shifts, for bit (pos-1)/2.
   int pos    [NI] = '{-1, -1, -1};
   int mcnt   [NI] = '{0, 0, 0};
   bit mdone  [NI] = '{0, 0, 0};
   bit msgn   [NI] = '{0, 0, 0};
   bit marmed [NI] = '{1, 1, 1};

   always @(posedge Clk) begin : model
      int  w;
      bit  was_clr;
      for (int i = 0; i < NI; i++) begin
         w = w_of(i);
         if (!Reset_n) begin
            pos[i]    = -1;
            mcnt[i]   = 0;
            mdone[i]  = 1'b0;
            msgn[i]   = 1'b0;
            marmed[i] = 1'b1;
         end else if (!Busy) begin
            was_clr = (pos[i] == 0);
            if (pos[i] < 0) begin
               if (Run && marmed[i]) pos[i] = 0;
            end else if (pos[i] == 2 * w) begin
               pos[i]   = -1;
               mdone[i] = 1'b1;
               mcnt[i]  = w;
            end else begin
               if (was_clr) msgn[i] = Signed_Mode;
               pos[i] = pos[i] + 1;
            end
            if (!Run) marmed[i] = 1'b1;
            else if (was_clr) marmed[i] = 1'b0;
         end
      end
   end

   always @(negedge Clk) begin : compare
      logic [10:0] e;
      logic [10:0] a;
      logic [4:0]  bc;
      int          w;
      int          b;
      bit          go;
      bit          odd;
      bit          neg;
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            w = w_of(i);
            case (i)
               0:       bc = {1'b0, bc0};
               1:       bc = {3'b000, bc1};
               default: bc = bc2;
            endcase
            a = {clr_ld[i], clr_a[i], add[i], sub[i],
                 shift[i], done[i], bc};
            e = '0;
            if (Reset_n) begin
               go   = !Busy;
               odd  = (pos[i] > 0) && (pos[i] % 2 == 1);
               b    = (pos[i] - 1) / 2;
               neg  = (b == w - 1) && msgn[i];
               e[10] = go && pos[i] < 0 && Load_Clear;
               e[9]  = go && pos[i] == 0;
               e[8]  = go && odd && m[i] && !neg;
               e[7]  = go && odd && m[i] && neg;
               e[6]  = go && pos[i] > 0 && pos[i] % 2 == 0;
               e[5]  = pos[i] < 0 && mdone[i];
               e[4:0] = (pos[i] >= 1) ? 5'(b) : 5'(mcnt[i]);
            end
            nchk++;
            if (a !== e) begin
               nerr++;
               $display("FAIL model u%0d @%0t: got %b, expected %b",
                        i, $time, a, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   int first_done [NI];
   int n_add;
   int n_sub;
   int add_k1;
   int sub_k;
   int done_k1;

   // Drive one run; cycle k is the k-th cycle after Run is sampled.
   task automatic run_seq(input int pat, input int stall_at,
                          input int ncyc, input bit smode);
      for (int i = 0; i < NI; i++) first_done[i] = -1;
      n_add = 0;
      n_sub = 0;
      add_k1 = -1;
      sub_k = -1;
      done_k1 = -1;
      Run = 1'b1;
      Load_Clear = 1'b0;
      Busy = 1'b0;
      Signed_Mode = smode;
      for (int k = 1; k <= ncyc; k++) begin
         step();
         Busy = (stall_at > 0) && (k >= stall_at) && (k < stall_at + 3);
         if (pat == 2 && k >= 2) Signed_Mode = (k % 2 == 1);
         case (pat)
            1:       m = 3'b111;
            2:       m = {2'($urandom), (k == 2 || k == 16)};
            default: m = 3'($urandom);
         endcase
         #4;
         for (int i = 0; i < NI; i++)
            if (done[i] && first_done[i] < 0) first_done[i] = k;
         if (k == 1) done_k1 = int'(done[0]);
         if (add[0]) begin
            n_add++;
            if (add_k1 < 0) add_k1 = k;
         end
         if (sub[0]) begin
            n_sub++;
            sub_k = k;
         end
      end
   endtask

   initial begin
      Reset_n = 1'b0;
      Run = 1'b0;
      Load_Clear = 1'b1;
      Signed_Mode = 1'b0;
      Busy = 1'b0;
      m = 3'b000;
      chk_en = 1'b1;
      step();
      step();
      #4;
      chk("rst_clr_ld", int'(clr_ld), 0);
      chk("rst_done", int'(done), 0);
      #1;
      Reset_n = 1'b1;
      #9;
      step();
      #4;
      chk("idle_clr_ld", int'(clr_ld), 7);
      chk("idle_bc", int'(bc0), 0);
      chk("idle_done", int'(done), 0);
      #1;

      // Unsigned, M=1 every bit, Run held past completion
      run_seq(1, 0, 40, 1'b0);
      chk("uns_done_w8", first_done[0], 18);
      chk("uns_done_w2", first_done[1], 6);
      chk("uns_done_w16", first_done[2], 34);
      chk("uns_adds", n_add, 8);
      chk("uns_first_add", add_k1, 2);
      chk("uns_subs", n_sub, 0);
      chk("uns_bc_w8", int'(bc0), 8);
      chk("uns_bc_w2", int'(bc1), 2);
      chk("uns_bc_w16", int'(bc2), 16);
      chk("held_done", int'(done), 7);

      // Drop Run one cycle, then a signed run from DONE
      Run = 1'b0;
      step();
      run_seq(2, 0, 40, 1'b1);
      chk("sgn_done_drop", done_k1, 0);
      chk("sgn_adds", n_add, 1);
      chk("sgn_first_add", add_k1, 2);
      chk("sgn_subs", n_sub, 1);
      chk("sgn_sub_cycle", sub_k, 16);
      chk("sgn_done_w8", first_done[0], 18);

      // Three-cycle stall starting at cycle 5
      Run = 1'b0;
      step();
      run_seq(1, 5, 44, 1'b0);
      chk("stall_done_w8", first_done[0], 21);
      chk("stall_adds", n_add, 8);
      chk("stall_bc_w8", int'(bc0), 8);

      // Reset asserted in cycle 9 of a run
      Run = 1'b0;
      step();
      run_seq(0, 0, 8, 1'b0);
      step();
      Reset_n = 1'b0;
      Run = 1'b0;
      #4;
      chk("mid_rst_strobes",
          int'({clr_ld, clr_a, add, sub, shift}), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_bc", int'(bc0), 0);
      #1;
      step();
      Reset_n = 1'b1;
      #4;
      chk("post_rst_done", int'(done), 0);
      chk("post_rst_bc", int'(bc2), 0);
      #1;

      // Randomised traffic, checked by the model every cycle
      for (int c = 0; c < 4000; c++) begin
         step();
         Reset_n = ($urandom % 300) != 0;
         Run = ($urandom % 4) != 0;
         Load_Clear = 1'($urandom);
         Signed_Mode = 1'($urandom);
         Busy = ($urandom % 6) == 0;
         m = 3'($urandom);
      end
      step();
      step();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Parametrised sequencing controller for the shift-add multiplier datapath, generalised to any operand width, with explicit separate add and shift cycles, an optional signed (two's-complement) mode, a stall input and a Done handshake. It sits between the switch/button inputs and the accumulator/shift-register datapath, issuing one-cycle strobes that the datapath registers act on. All strobes are forced inactive during a stall. A run happens once per Run press rather than repeating while Run is held.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- CW, $clog2(WIDTH+1), width of Bit_Count (derived, not overridden)
- Clk  in  1  system clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Run  in  1  start request, level input, already synchronised
- Load_Clear  in  1  load-operand request, honoured only in IDLE or DONE
- M  in  1  current multiplier LSB from the datapath
- Signed_Mode  in  1  1 = two's-complement multiply; sampled in CLRA
- Busy  in  1  stall; holds state and count
- Clr_Ld  out  1  load operand B, clear A and X
- Clr_A  out  1  clear A and X only, at the start of a run
- Add  out  1  A <= A + S
- Sub  out  1  A <= A - S
- Shift  out  1  arithmetic shift right of X:A:B
- Done  out  1  result valid
- Bit_Count  out  CW  number of shifts completed in the current run

## Operation
- The block has five states: IDLE, CLRA, ADD, SHIFT and DONE.
- **Reset.** Reset_n low forces the following immediately and asynchronously:
  - state = IDLE
  - Bit_Count = 0
  - signed latch = 0
  - run-armed flag = 1
  - all outputs = 0
- **IDLE**
  - Clr_Ld = Load_Clear.
  - If Run = 1 and armed, go to CLRA.
- **CLRA**
  - Clr_A = 1.
  - Bit_Count <= 0.
  - Latch Signed_Mode.
  - Clear the armed flag.
  - Go to ADD.
- **ADD**
  - If M = 1 and this is the last bit (Bit_Count == WIDTH-1) and signed latch = 1, assert Sub = 1.
  - Otherwise, if M = 1, assert Add = 1.
  - If M = 0, assert neither.
  - Add and Sub are combinational on M within the state.
  - Always go to SHIFT.
- **SHIFT**
  - Shift = 1.
  - Bit_Count <= Bit_Count + 1.
  - If Bit_Count == WIDTH-1 (before the increment), go to DONE; otherwise go to ADD.
- **DONE**
  - Done = 1.
  - Clr_Ld = Load_Clear.
  - When Run = 1 and armed, go to CLRA (new run; A/X cleared, B keeps the result).
- **Re-arming.** The armed flag sets in any state whenever Run = 0 is sampled. Holding Run high through and past completion therefore never starts a second run.
- **Busy = 1.**
  - Next state, Bit_Count, the signed latch and the armed flag all hold.
  - Clr_Ld, Clr_A, Add, Sub and Shift are 0.
  - Done still reflects the state.
- **Mutual exclusion.**
  - At most one of Clr_Ld, Clr_A, Add, Sub, Shift is 1 in any cycle.
  - Add and Sub are never both 1.
- **Load_Clear** is ignored in CLRA, ADD and SHIFT.
- **Signed_Mode** changes mid-run are ignored; the latched value is used.
- **Bit_Count** saturates at WIDTH in DONE and never wraps.

## Timing
- Edge 0: Run is sampled high in IDLE or DONE.
- Cycle 1: CLRA.
- Cycles 2i+2 and 2i+3 are ADD and SHIFT, for i = 0..WIDTH-1.
- Done first goes high in cycle 2*WIDTH+2; for WIDTH = 8 that is cycle 18.
- Each Busy cycle adds exactly one cycle of latency at the point where it occurs.
- Strobes are valid for exactly one cycle per state visit; the datapath acts on the edge that ends the cycle.
- A Reset_n assertion mid-run aborts the run immediately. Release returns to IDLE, armed, on the next edge.
- Done drops in the cycle CLRA is entered.
- If Run and Load_Clear are high together in DONE:
  - Clr_Ld = 1 in that cycle.
  - CLRA follows on the next edge.

## Test plan
- **Reset/idle.**
  - Stimulus: Reset_n low, then release with Run = 0 and Load_Clear = 1.
  - Response: all strobes 0 during reset; Clr_Ld = 1 after release; Bit_Count = 0; Done = 0.
- **Unsigned run, WIDTH = 8, M = 1 every ADD.**
  - Add is high in cycles 2,4,…,16.
  - Shift is high in cycles 3,…,17.
  - Sub is never high.
  - Done is high from cycle 18.
  - Bit_Count = 8.
- **Signed run, WIDTH = 8, M = 1 at bits 0 and 7, Signed_Mode = 1.**
  - Add is high in cycle 2 only.
  - Sub is high in cycle 16.
  - Toggling Signed_Mode after CLRA has no effect.
- **Stall.**
  - Stimulus: Busy = 1 for 3 cycles starting at cycle 5.
  - Response: no strobes and no Bit_Count change during the stall; Done at cycle 21; the strobe sequence is otherwise identical.
- **Run held.**
  - Stimulus: Run high continuously from start.
  - Response: exactly one run; DONE persists.
  - Then drop Run for 1 cycle and raise it: CLRA follows, Done drops, and the full sequence repeats.
- **Parameter sweep.**
  - WIDTH = 2 and WIDTH = 16: Done first high at cycles 6 and 34 respectively.
  - Mid-run reset at cycle 9 returns to IDLE with all outputs 0.
